ahf_core_link_v: RTL and testbench
==================================

// Module: ahf_core_link_v
// PURPOSE
// - Bidirectional mailbox link between two RISC521 cores (side A, side B).
// - Consumes a core's Write/Data_out strobe and produces that core's Data_in/Done_in slice.
// - Holds one FIFO per direction, so the sender never waits for the receiver to issue LD.
// - One instance per core pair; each core's channel bit k wires to exactly one link.
// PARAMETERS
// - WIDTH   14  data word width (core word size)
// - DEPTH   4   words per direction FIFO; power of two
// - ADDR_W  2   log2(DEPTH)
// PORTS
// - Clk_pin0   in   1        single clock; all state on posedge
// - Reset_pin  in   1        asynchronous, active-low reset
// - a_write    in   1        side A Write[k]; level request, held until a_done=0
// - a_read     in   1        side A Read[k]; level request, held until a_done=0
// - a_wdata    in   WIDTH    side A Data_out, valid while a_write=1
// - a_rdata    out  WIDTH    side A Data_in slice; word popped from B->A FIFO
// - a_done     out  1        side A Done_in[k]; 0 = request completed, 1 = busy/idle
// - b_write, b_read, b_wdata, b_rdata, b_done   same as side A, mirrored
// - a2b_count  out  ADDR_W+1 words queued A->B (0..DEPTH)
// - b2a_count  out  ADDR_W+1 words queued B->A (0..DEPTH)
// BEHAVIOUR
// - Reset (Reset_pin=0, async):
//   - Both FIFOs flushed; pointers/counts=0.
//   - Side FSMs -> IDLE; a_done=b_done=1; a_rdata=b_rdata=0.
//   - Reset mid-handshake discards the pending word; no push/pop survives.
// - Per-side FSM, states IDLE, WR_ACK, RD_ACK. Side A shown; side B identical.
//   - IDLE, a_write=1, A->B not full: push a_wdata at this edge -> WR_ACK, a_done<=0.
//   - IDLE, a_write=1, A->B full: stay IDLE, a_done=1; core stalls until space frees.
//   - IDLE, a_read=1, a_write=0, B->A not empty: pop; a_rdata<=head -> RD_ACK, a_done<=0.
//   - IDLE, a_read=1, B->A empty: stay IDLE, a_done=1.
//   - IDLE, a_write=1 and a_read=1 together: write has priority; read served after return to IDLE.
//   - WR_ACK/RD_ACK: hold a_done=0 and a_rdata stable until the request drops.
//   - Then -> IDLE with a_done<=1. Exactly one push/pop per request level.
//   - Request dropped while still IDLE (never accepted): no FIFO effect.
// - Latency:
//   - Request sampled at edge N -> a_done=0 after edge N; core completes at edge N+1.
//   - Minimum 2 cycles per transfer.
//   - Word pushed at edge N is poppable by the other side at edge N+1 (no bypass).
// - Simultaneous events:
//   - Push A->B and pop A->B (by B) at same edge is legal at any count, including full and empty.
//   - Pop on full frees space for A from the next edge; push on empty is readable from the next edge.
//   - Count = count + push - pop; never exceeds DEPTH, never underflows.
// - Pointers are ADDR_W bits and wrap modulo DEPTH.
// - Full is count==DEPTH; empty is count==0.
// - a_rdata changes only on a pop by side A.
// STRUCTURE
// - Shared package / include ahf_risc521_pkg:
//   - WORD_W=14
//   - link FSM state encodings LK_IDLE=2'b00, LK_WR_ACK=2'b01, LK_RD_ACK=2'b10
// - Sub-module ahf_link_fifo_v (WIDTH, DEPTH, ADDR_W):
//   - Ports: push, pop, din, dout(head), count, full, empty.
//   - Synchronous register array; async active-low reset of pointers and count.
//   - Instantiated twice (A->B, B->A).
// - Top holds the two side FSMs and the done/rdata registers.
// TESTING
// - Reset, then A writes 14'h1234:
//   - a_done falls 1 cycle after a_write, a2b_count=1.
//   - B reads: b_rdata=14'h1234, b_done=0, count=0.
// - A writes 0x0001..0x0004 (DEPTH=4), then a 5th write 0x0005:
//   - a_done stays 1.
//   - B reads one word (0x0001); a_done falls on the next cycle.
//   - FIFO then holds 0x0002..0x0005 in order.
// - B reads from empty B->A: b_done=1 for 10 cycles.
//   - A writes 14'h3ABC: b_done falls 2 cycles later, b_rdata=14'h3ABC.
// - Same-edge push by A and pop by B at count=4: count stays 4, order preserved; repeat at count=0.
// - Both directions concurrently, 20 words each (A: 0x0100+i, B: 0x0200+i): both receivers see exact sequences.
// - Reset pulsed while in WR_ACK with count=2:
//   - Counts=0, a_done=1, a_rdata=0.
//   - Next read stalls until a new write.

Source files
------------

// File: rtl/ahf_risc521_pkg.sv
// Shared RISC521 definitions: core word width and the mailbox-link side FSM encoding.
package ahf_risc521_pkg;

    localparam int WORD_W = 14;

    typedef enum logic [1:0] {
        LK_IDLE   = 2'b00,
        LK_WR_ACK = 2'b01,
        LK_RD_ACK = 2'b10
    } lk_state_e;

endpackage

// File: rtl/ahf_link_fifo_v.sv
// One-direction mailbox FIFO: register array with head-of-queue output and a word count.
// The head is visible combinationally; a word pushed at an edge is poppable from the next edge.
module ahf_link_fifo_v #(
    parameter int WIDTH  = 14,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              Clk_pin0,
    input  logic              Reset_pin,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (ADDR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    // A push on full is only safe when the head leaves at the same edge; no bypass on empty.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge Clk_pin0) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge Clk_pin0 or negedge Reset_pin) begin
        if (!Reset_pin) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ahf_core_link_v.sv
// Bidirectional mailbox link between two RISC521 cores: one FIFO per direction and a
// request/done handshake FSM per side that performs exactly one push or pop per request level.
module ahf_core_link_v
    import ahf_risc521_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              Clk_pin0,
    input  logic              Reset_pin,
    input  logic              a_write,
    input  logic              a_read,
    input  logic [WIDTH-1:0]  a_wdata,
    output logic [WIDTH-1:0]  a_rdata,
    output logic              a_done,
    input  logic              b_write,
    input  logic              b_read,
    input  logic [WIDTH-1:0]  b_wdata,
    output logic [WIDTH-1:0]  b_rdata,
    output logic              b_done,
    output logic [ADDR_W:0]   a2b_count,
    output logic [ADDR_W:0]   b2a_count
);

    lk_state_e        a_state, a_state_nxt;
    lk_state_e        b_state, b_state_nxt;
    logic             a_push, a_pop, b_push, b_pop;
    logic             ab_full, ab_empty, ba_full, ba_empty;
    logic [WIDTH-1:0] ab_head, ba_head;

    ahf_link_fifo_v #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_a2b (
        .Clk_pin0 (Clk_pin0),
        .Reset_pin(Reset_pin),
        .push     (a_push),
        .pop      (b_pop),
        .din      (a_wdata),
        .dout     (ab_head),
        .count    (a2b_count),
        .full     (ab_full),
        .empty    (ab_empty)
    );

    ahf_link_fifo_v #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_b2a (
        .Clk_pin0 (Clk_pin0),
        .Reset_pin(Reset_pin),
        .push     (b_push),
        .pop      (a_pop),
        .din      (b_wdata),
        .dout     (ba_head),
        .count    (b2a_count),
        .full     (ba_full),
        .empty    (ba_empty)
    );

    // Write outranks read: a stalled write also blocks a pending read on that side.
    always_comb begin
        a_state_nxt = a_state;
        a_push      = 1'b0;
        a_pop       = 1'b0;
        case (a_state)
            LK_IDLE: begin
                if (a_write) begin
                    if (!ab_full) begin
                        a_push      = 1'b1;
                        a_state_nxt = LK_WR_ACK;
                    end
                end else if (a_read && !ba_empty) begin
                    a_pop       = 1'b1;
                    a_state_nxt = LK_RD_ACK;
                end
            end
            LK_WR_ACK: if (!a_write) a_state_nxt = LK_IDLE;
            LK_RD_ACK: if (!a_read)  a_state_nxt = LK_IDLE;
            default:   a_state_nxt = LK_IDLE;
        endcase
    end

    always_comb begin
        b_state_nxt = b_state;
        b_push      = 1'b0;
        b_pop       = 1'b0;
        case (b_state)
            LK_IDLE: begin
                if (b_write) begin
                    if (!ba_full) begin
                        b_push      = 1'b1;
                        b_state_nxt = LK_WR_ACK;
                    end
                end else if (b_read && !ab_empty) begin
                    b_pop       = 1'b1;
                    b_state_nxt = LK_RD_ACK;
                end
            end
            LK_WR_ACK: if (!b_write) b_state_nxt = LK_IDLE;
            LK_RD_ACK: if (!b_read)  b_state_nxt = LK_IDLE;
            default:   b_state_nxt = LK_IDLE;
        endcase
    end

    // Done is low exactly while the side sits in an acknowledge state.
    always_ff @(posedge Clk_pin0 or negedge Reset_pin) begin
        if (!Reset_pin) begin
            a_state <= LK_IDLE;
            b_state <= LK_IDLE;
            a_done  <= 1'b1;
            b_done  <= 1'b1;
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            a_state <= a_state_nxt;
            b_state <= b_state_nxt;
            a_done  <= (a_state_nxt == LK_IDLE);
            b_done  <= (b_state_nxt == LK_IDLE);
            if (a_pop) begin
                a_rdata <= ba_head;
            end
            if (b_pop) begin
                b_rdata <= ab_head;
            end
        end
    end

endmodule

// File: tb/tb_ahf_core_link_v.sv
// Bench for ahf_core_link_v: directed handshake scenarios plus randomized two-sided traffic,
// compared every cycle against a queue-based transaction model of the link.
module tb_ahf_core_link_v;

    localparam int WIDTH  = 14;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int TMO    = 200;

    logic              Clk_pin0  = 1'b0;
    logic              Reset_pin = 1'b0;
    logic              a_write = 1'b0, a_read = 1'b0;
    logic              b_write = 1'b0, b_read = 1'b0;
    logic [WIDTH-1:0]  a_wdata = '0, b_wdata = '0;
    logic [WIDTH-1:0]  a_rdata, b_rdata;
    logic              a_done, b_done;
    logic [ADDR_W:0]   a2b_count, b2a_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk_pin0 = ~Clk_pin0;

    ahf_core_link_v #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .Clk_pin0 (Clk_pin0),
        .Reset_pin(Reset_pin),
        .a_write  (a_write),
        .a_read   (a_read),
        .a_wdata  (a_wdata),
        .a_rdata  (a_rdata),
        .a_done   (a_done),
        .b_write  (b_write),
        .b_read   (b_read),
        .b_wdata  (b_wdata),
        .b_rdata  (b_rdata),
        .b_done   (b_done),
        .a2b_count(a2b_count),
        .b2a_count(b2a_count)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Transaction model: one queue per direction, each side either free or holding an
    // accepted request (write or read) until that request line drops.
    logic [WIDTH-1:0] q_ab[$];
    logic [WIDTH-1:0] q_ba[$];
    bit               m_a_busy = 0, m_a_wr = 0, m_b_busy = 0, m_b_wr = 0;
    logic             m_a_done = 1'b1, m_b_done = 1'b1;
    logic [WIDTH-1:0] m_a_rdata = '0, m_b_rdata = '0;

    initial begin
        forever begin
            @(posedge Clk_pin0 or negedge Reset_pin);
            if (!Reset_pin) begin
                q_ab.delete();
                q_ba.delete();
                m_a_busy = 0; m_b_busy = 0;
                m_a_done = 1'b1; m_b_done = 1'b1;
                m_a_rdata = '0; m_b_rdata = '0;
            end else begin
                int  nab, nba;
                bit  ap, aq, bp, bq;
                nab = q_ab.size();
                nba = q_ba.size();
                ap = 0; aq = 0; bp = 0; bq = 0;
                if (!m_a_busy) begin
                    if (a_write) ap = (nab < DEPTH);
                    else if (a_read) aq = (nba > 0);
                end else if (m_a_wr ? !a_write : !a_read) begin
                    m_a_busy = 0; m_a_done = 1'b1;
                end
                if (!m_b_busy) begin
                    if (b_write) bp = (nba < DEPTH);
                    else if (b_read) bq = (nab > 0);
                end else if (m_b_wr ? !b_write : !b_read) begin
                    m_b_busy = 0; m_b_done = 1'b1;
                end
                if (aq) begin m_a_rdata = q_ba.pop_front(); m_a_busy = 1; m_a_wr = 0; m_a_done = 1'b0; end
                if (bq) begin m_b_rdata = q_ab.pop_front(); m_b_busy = 1; m_b_wr = 0; m_b_done = 1'b0; end
                if (ap) begin q_ab.push_back(a_wdata); m_a_busy = 1; m_a_wr = 1; m_a_done = 1'b0; end
                if (bp) begin q_ba.push_back(b_wdata); m_b_busy = 1; m_b_wr = 1; m_b_done = 1'b0; end
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clk_pin0);
            check_val("m_a_done",  a_done,    m_a_done);
            check_val("m_b_done",  b_done,    m_b_done);
            check_val("m_a_rdata", a_rdata,   m_a_rdata);
            check_val("m_b_rdata", b_rdata,   m_b_rdata);
            check_val("m_a2b_cnt", a2b_count, q_ab.size());
            check_val("m_b2a_cnt", b2a_count, q_ba.size());
        end
    end

    task automatic a_write_word(input logic [WIDTH-1:0] d);
        int t = 0;
        @(negedge Clk_pin0);
        a_wdata = d; a_write = 1'b1;
        do begin @(negedge Clk_pin0); t++; end while (a_done !== 1'b0 && t < TMO);
        check_val("a_wr_ack", a_done, 0);
        a_write = 1'b0;
    endtask

    task automatic b_write_word(input logic [WIDTH-1:0] d);
        int t = 0;
        @(negedge Clk_pin0);
        b_wdata = d; b_write = 1'b1;
        do begin @(negedge Clk_pin0); t++; end while (b_done !== 1'b0 && t < TMO);
        check_val("b_wr_ack", b_done, 0);
        b_write = 1'b0;
    endtask

    task automatic a_read_word(output logic [WIDTH-1:0] d);
        int t = 0;
        @(negedge Clk_pin0);
        a_read = 1'b1;
        do begin @(negedge Clk_pin0); t++; end while (a_done !== 1'b0 && t < TMO);
        check_val("a_rd_ack", a_done, 0);
        d = a_rdata;
        a_read = 1'b0;
    endtask

    task automatic b_read_word(output logic [WIDTH-1:0] d);
        int t = 0;
        @(negedge Clk_pin0);
        b_read = 1'b1;
        do begin @(negedge Clk_pin0); t++; end while (b_done !== 1'b0 && t < TMO);
        check_val("b_rd_ack", b_done, 0);
        d = b_rdata;
        b_read = 1'b0;
    endtask

    // Random request that the core may abandon if it is not accepted within a few cycles.
    task automatic a_rand_req();
        int t = 0;
        int lim = $urandom_range(1, 6);
        int kind = $urandom_range(0, 2);
        @(negedge Clk_pin0);
        a_wdata = WIDTH'($urandom);
        a_write = (kind != 1);
        a_read  = (kind != 0);
        do begin @(negedge Clk_pin0); t++; end while (a_done !== 1'b0 && t < lim);
        a_write = 1'b0; a_read = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge Clk_pin0);
    endtask

    task automatic b_rand_req();
        int t = 0;
        int lim = $urandom_range(1, 6);
        int kind = $urandom_range(0, 2);
        @(negedge Clk_pin0);
        b_wdata = WIDTH'($urandom);
        b_write = (kind != 1);
        b_read  = (kind != 0);
        do begin @(negedge Clk_pin0); t++; end while (b_done !== 1'b0 && t < lim);
        b_write = 1'b0; b_read = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge Clk_pin0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] d;

        repeat (3) @(posedge Clk_pin0);
        #3 Reset_pin = 1'b1;
        @(negedge Clk_pin0);
        check_val("rst_a_done", a_done, 1);
        check_val("rst_b_done", b_done, 1);
        check_val("rst_a2b", a2b_count, 0);

        // single word A->B
        a_wdata = 14'h1234; a_write = 1'b1;
        @(negedge Clk_pin0);
        check_val("t1_a_done", a_done, 0);
        check_val("t1_a2b", a2b_count, 1);
        a_write = 1'b0;
        b_read_word(d);
        check_val("t1_b_rdata", d, 14'h1234);
        check_val("t1_a2b_after", a2b_count, 0);

        // fill, stall on full, release by one pop
        for (int i = 1; i <= 4; i++) a_write_word(WIDTH'(i));
        @(negedge Clk_pin0);
        a_wdata = 14'h0005; a_write = 1'b1;
        repeat (3) begin
            @(negedge Clk_pin0);
            check_val("t2_full_stall", a_done, 1);
        end
        b_read = 1'b1;
        @(negedge Clk_pin0);
        check_val("t2_b_done", b_done, 0);
        check_val("t2_b_rdata", b_rdata, 14'h0001);
        check_val("t2_a_still", a_done, 1);
        b_read = 1'b0;
        @(negedge Clk_pin0);
        check_val("t2_a_done", a_done, 0);
        check_val("t2_a2b", a2b_count, 4);
        a_write = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            b_read_word(d);
            check_val("t2_order", d, i);
        end

        // read on empty waits for the other side
        @(negedge Clk_pin0);
        b_read = 1'b1;
        repeat (10) begin
            @(negedge Clk_pin0);
            check_val("t3_empty_stall", b_done, 1);
        end
        a_wdata = 14'h3ABC; a_write = 1'b1;
        @(negedge Clk_pin0);
        check_val("t3_b_wait", b_done, 1);
        @(negedge Clk_pin0);
        check_val("t3_b_done", b_done, 0);
        check_val("t3_b_rdata", b_rdata, 14'h3ABC);
        a_write = 1'b0; b_read = 1'b0;

        // same-edge push and pop at count 0: no bypass
        @(negedge Clk_pin0);
        a_wdata = 14'h0AAA; a_write = 1'b1; b_read = 1'b1;
        @(negedge Clk_pin0);
        check_val("t4_e_cnt", a2b_count, 1);
        check_val("t4_e_bwait", b_done, 1);
        a_write = 1'b0;
        @(negedge Clk_pin0);
        check_val("t4_e_rdata", b_rdata, 14'h0AAA);
        check_val("t4_e_cnt2", a2b_count, 0);
        b_read = 1'b0;

        // same-edge write and pop at count 4
        for (int i = 0; i < 4; i++) a_write_word(WIDTH'(16 + i));
        @(negedge Clk_pin0);
        a_wdata = 14'h0014; a_write = 1'b1; b_read = 1'b1;
        @(negedge Clk_pin0);
        check_val("t4_f_rdata", b_rdata, 14'h0010);
        b_read = 1'b0;
        @(negedge Clk_pin0);
        check_val("t4_f_cnt", a2b_count, 4);
        a_write = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            b_read_word(d);
            check_val("t4_f_order", d, 16 + i);
        end

        // both directions concurrently
        fork
            begin
                logic [WIDTH-1:0] ra;
                for (int i = 0; i < 20; i++) begin
                    a_write_word(WIDTH'(16'h0100 + i));
                    a_read_word(ra);
                    check_val("t5_a_seq", ra, 16'h0200 + i);
                    repeat ($urandom_range(0, 3)) @(negedge Clk_pin0);
                end
            end
            begin
                logic [WIDTH-1:0] rb;
                for (int j = 0; j < 20; j++) begin
                    b_write_word(WIDTH'(16'h0200 + j));
                    b_read_word(rb);
                    check_val("t5_b_seq", rb, 16'h0100 + j);
                    repeat ($urandom_range(0, 3)) @(negedge Clk_pin0);
                end
            end
        join

        // reset in the middle of a write acknowledge
        a_write_word(14'h0111);
        @(negedge Clk_pin0);
        a_wdata = 14'h0222; a_write = 1'b1;
        @(negedge Clk_pin0);
        check_val("t6_pre_cnt", a2b_count, 2);
        check_val("t6_pre_ack", a_done, 0);
        #2 Reset_pin = 1'b0; a_write = 1'b0;
        #1;
        check_val("t6_rst_cnt", a2b_count, 0);
        check_val("t6_rst_b2a", b2a_count, 0);
        check_val("t6_rst_done", a_done, 1);
        check_val("t6_rst_rdata", a_rdata, 0);
        @(posedge Clk_pin0);
        #3 Reset_pin = 1'b1;
        @(negedge Clk_pin0);
        b_read = 1'b1;
        repeat (5) begin
            @(negedge Clk_pin0);
            check_val("t6_rd_stall", b_done, 1);
        end
        a_wdata = 14'h0333; a_write = 1'b1;
        repeat (2) @(negedge Clk_pin0);
        check_val("t6_b_done", b_done, 0);
        check_val("t6_b_rdata", b_rdata, 14'h0333);
        a_write = 1'b0; b_read = 1'b0;

        // randomized two-sided traffic, checked cycle by cycle against the model
        fork
            repeat (150) a_rand_req();
            repeat (150) b_rand_req();
        join
        repeat (3) @(negedge Clk_pin0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
